io881_uart_tx: RTL and testbench

- Serial transmit stage that sits directly downstream of the io881 transmit FIFO.
- Pops one word at a time from the FIFO output through a valid/ready handshake.
- Serialises each word as an asynchronous 8N1-style frame (start bit, DATA_BITS LSB-first, one stop bit) on txd.
- Bit timing comes from a run-time clock divisor, so the same block serves every baud rate the host programs.

---
 rtl/io881_uart_tx.sv | 117 +++++++++++
 tb/tb_io881_uart_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/io881_uart_tx.sv
// Serial transmit stage for the io881 TX FIFO: pops one word per frame and
// sends start bit, DATA_BITS data bits LSB-first and one stop bit on txd.
module io881_uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 in_valid,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 in_ready,
   output logic                 txd,
   output logic                 busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic [1:0]           state_q,   state_d;
   logic [DIV_WIDTH-1:0] cnt_q,     cnt_d;
   logic [DIV_WIDTH-1:0] period_q,  period_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic                 txd_q,     txd_d;
   logic                 busy_q,    busy_d;

   assign in_ready = (state_q == ST_IDLE);
   assign txd      = txd_q;
   assign busy     = busy_q;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case leaves a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      txd_d     = txd_q;
      busy_d    = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d  = ST_START;
               shift_d  = in_data;
               period_d = divisor;
               cnt_d    = divisor;
               txd_d    = 1'b0;
               busy_d   = 1'b1;
            end
         end
         ST_START: begin
            if (cnt_q == '0) begin
               state_d   = ST_DATA;
               bit_idx_d = '0;
               cnt_d     = period_q;
               txd_d     = shift_q[0];
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
               shift_d = shift_q >> 1;
               cnt_d   = period_q;
               if (bit_idx_q == LAST_IDX) begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
                  // txd is registered, so it must already carry the next bit
                  txd_d     = shift_d[0];
               end
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_io881_uart_tx.sv
// Self-checking bench for io881_uart_tx: directed frame table, hand-written
// corner sequences, and a randomized run against a frame-level reference model.
module tb_io881_uart_tx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] divisor;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        txd;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   io881_uart_tx #(.DATA_BITS(8), .DIV_WIDTH(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .divisor  (divisor),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .txd      (txd),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] div;
      int          len;
      logic [9:0]  bits;   // bit i = i-th bit on the line (start first)
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pushes one word, then follows the whole frame sample by sample.
   task automatic send_frame(input logic [7:0] data, input logic [15:0] div,
                             input int chg_at, input logic [15:0] chg_div,
                             input int exp_len, input logic [9:0] exp_bits,
                             input string name);
      int n, bad, rdy_hi, idx;
      @(negedge clk);
      in_data  = data;
      divisor  = div;
      in_valid = 1'b1;
      check({name, " ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      n = 0; bad = 0; rdy_hi = 0;
      while (busy === 1'b1 && n < 2000) begin
         idx = n / (int'(div) + 1);
         if (idx > 9 || txd !== exp_bits[idx]) bad++;
         if (in_ready !== 1'b0) rdy_hi++;
         n++;
         if (n == chg_at) divisor = chg_div;
         @(negedge clk);
      end
      check({name, " length"}, 64'(n), 64'(exp_len));
      check({name, " bits"}, 64'(bad), 64'd0);
      check({name, " no pop mid-frame"}, 64'(rdy_hi), 64'd0);
      check({name, " idle after"}, {62'd0, txd, in_ready}, 64'b11);
   endtask

   logic [1:0] exp_q[$];
   logic [7:0] fifo[$];
   logic [1:0] rec_b[60];
   logic [1:0] rec_t[60];

   initial begin
      int pops, bad, p;
      logic [1:0] e;
      logic       idle;
      logic [7:0] w;
      logic [9:0] fb;
      logic [9:0] f0;
      logic [9:0] f1;

      vecs[0] = '{8'hA5, 16'd3, 40, 10'b1101001010};
      vecs[1] = '{8'h01, 16'd0, 10, 10'b1000000010};
      vecs[2] = '{8'h00, 16'd1, 20, 10'b1000000000};
      vecs[3] = '{8'hFF, 16'd1, 20, 10'b1111111110};
      vecs[4] = '{8'h81, 16'd2, 30, 10'b1100000010};

      // Reset held with a word waiting: line must stay idle.
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      divisor  = 16'd3;
      repeat (3) begin
         @(negedge clk);
         check("reset idle", {62'd0, txd, busy}, 64'b10);
      end
      reset_n  = 1'b1;
      in_valid = 1'b0;
      #1;
      check("ready after release", 64'(in_ready), 64'd1);

      for (int i = 0; i < 5; i++)
         send_frame(vecs[i].data, vecs[i].div, -1, 16'd0, vecs[i].len, vecs[i].bits,
                    $sformatf("vec%0d", i));

      // Back-to-back: 0x00 then 0xFF with divisor 1.
      @(negedge clk);
      divisor  = 16'd1;
      in_data  = 8'h00;
      in_valid = 1'b1;
      pops = 0;
      for (int i = 0; i < 60; i++) begin
         if (pops == 1) in_data = 8'hFF;
         if (pops >= 2) in_valid = 1'b0;
         rec_b[i] = {1'b0, busy};
         rec_t[i] = {1'b0, txd};
         if (in_ready && in_valid) pops++;
         @(negedge clk);
      end
      check("b2b pops", 64'(pops), 64'd2);
      f0 = 10'b1000000000;
      f1 = 10'b1111111110;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         if (i >= 1 && i <= 20) begin
            if (rec_b[i] != 2'd1 || rec_t[i][0] != f0[(i - 1) / 2]) bad++;
         end else if (i >= 22 && i <= 41) begin
            if (rec_b[i] != 2'd1 || rec_t[i][0] != f1[(i - 22) / 2]) bad++;
         end else if (rec_b[i] != 2'd0 || rec_t[i] != 2'd1) bad++;
      end
      check("b2b waveform", 64'(bad), 64'd0);
      check("b2b gap idle", {60'd0, rec_b[21], rec_t[21]}, 64'b0001);

      // Divisor moved to 7 during DATA: current frame keeps 4 clocks/bit.
      send_frame(8'h55, 16'd3, 10, 16'd7, 40, 10'b1010101010, "div change cur");
      send_frame(8'hC3, 16'd7, -1, 16'd0, 80, 10'b1110000110, "div change next");

      // Reset during data bit 3 of 0x3C.
      @(negedge clk);
      in_data  = 8'h3C;
      divisor  = 16'd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (17) @(negedge clk);
      check("pre-reset busy", 64'(busy), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async reset", {62'd0, txd, busy}, 64'b10);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("ready after mid reset", 64'(in_ready), 64'd1);
      send_frame(8'h81, 16'd3, -1, 16'd0, 40, 10'b1100000010, "after reset");

      // Randomized run against the frame-level model.
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         idle = (exp_q.size() == 0);
         if (idle) e = 2'b10;
         else      e = exp_q.pop_front();
         check("random", {61'd0, txd, busy, in_ready}, {61'd0, e, idle});
         if (fifo.size() < 4 && $urandom_range(0, 3) == 0) fifo.push_back(8'($urandom));
         divisor  = 16'($urandom_range(0, 3));
         in_valid = (fifo.size() > 0);
         in_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
         if (idle && in_valid) begin
            w  = fifo.pop_front();
            p  = int'(divisor);
            fb = {1'b1, w, 1'b0};
            for (int b = 0; b < 10; b++)
               for (int k = 0; k <= p; k++)
                  exp_q.push_back({fb[b], 1'b1});
         end
      end
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
